// File: rtl/whac_pkg.sv
// Shared Whac-A-Mole definitions: round state encodings and time constants.
// The display, mole and score blocks decode the same state values.
package whac_pkg;

  localparam int MS_PER_SECOND = 1000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESTART  = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_e;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider: one-cycle pulse every CLKS_PER_MS clocks.
// clr restarts the count so the next tick lands exactly CLKS_PER_MS cycles later.
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/game_controller.sv
// Whac-A-Mole round sequencer: IDLE -> PRESTART -> PLAYING <-> PAUSED -> GAME_OVER.
// Drives the countdown timer and gates mole spawning / scoring; outputs decode from the next state.
module game_controller
  import whac_pkg::*;
#(
  parameter int GAME_LENGTH_SECONDS = 20,
  parameter int CLKS_PER_MS         = 50000,
  parameter int PRESTART_SECONDS    = 3,
  parameter int GAMEOVER_HOLD_MS    = 2000
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 start_btn,
  input  logic                                                 pause_btn,
  input  logic [$clog2(MS_PER_SECOND*GAME_LENGTH_SECONDS)-1:0] timer_ms,
  output logic                                                 timer_rst,
  output logic                                                 timer_enable,
  output logic                                                 game_active,
  output logic                                                 score_clr,
  output logic                                                 game_over,
  output logic [$clog2(PRESTART_SECONDS+1)-1:0]                prestart_secs,
  output logic [2:0]                                           state
);

  localparam int PW = $clog2(PRESTART_SECONDS + 1);
  localparam int HW = $clog2(GAMEOVER_HOLD_MS + 1);
  localparam int MW = $clog2(MS_PER_SECOND);
  localparam logic [PW-1:0] PRE_LOAD = PW'(PRESTART_SECONDS);
  localparam logic [HW-1:0] HOLD_MAX = HW'(GAMEOVER_HOLD_MS);
  localparam logic [MW-1:0] MS_LAST  = MW'(MS_PER_SECOND - 1);

  game_state_e r_state;
  game_state_e w_next;
  logic        r_start_q, r_pause_q, r_armed;
  logic        r_timer_rst, r_timer_enable, r_game_active, r_score_clr, r_game_over;
  logic [PW-1:0] r_pre_secs;
  logic [MW-1:0] r_ms_cnt;
  logic [HW-1:0] r_hold;
  logic        w_start_ev, w_pause_ev, w_tick, w_tick_clr;
  logic        w_sec_done, w_hold_sat, w_enter_pre, w_enter_go;

  // r_armed masks the first cycle after reset so a button held through reset never fires.
  assign w_start_ev = r_armed && start_btn && !r_start_q;
  assign w_pause_ev = r_armed && pause_btn && !r_pause_q;
  assign w_sec_done = w_tick && (r_ms_cnt == MS_LAST);
  assign w_hold_sat = (r_hold == HOLD_MAX);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_start_ev) w_next = ST_PRESTART;
      ST_PRESTART:  if (w_sec_done && (r_pre_secs <= PW'(1))) w_next = ST_PLAYING;
      ST_PLAYING: begin
        if (timer_ms == '0)  w_next = ST_GAME_OVER;
        else if (w_pause_ev) w_next = ST_PAUSED;
      end
      ST_PAUSED:    if (w_pause_ev || w_start_ev) w_next = ST_PLAYING;
      ST_GAME_OVER: if (w_start_ev && w_hold_sat) w_next = ST_PRESTART;
      default:      w_next = ST_IDLE;
    endcase
  end

  assign w_enter_pre = (w_next == ST_PRESTART)  && (r_state != ST_PRESTART);
  assign w_enter_go  = (w_next == ST_GAME_OVER) && (r_state != ST_GAME_OVER);
  assign w_tick_clr  = w_enter_pre || w_enter_go;

  ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_tick_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_start_q      <= 1'b0;
      r_pause_q      <= 1'b0;
      r_armed        <= 1'b0;
      r_timer_rst    <= 1'b1;
      r_timer_enable <= 1'b0;
      r_game_active  <= 1'b0;
      r_score_clr    <= 1'b0;
      r_game_over    <= 1'b0;
      r_pre_secs     <= '0;
      r_ms_cnt       <= '0;
      r_hold         <= '0;
    end else begin
      r_start_q      <= start_btn;
      r_pause_q      <= pause_btn;
      r_armed        <= 1'b1;
      r_state        <= w_next;
      r_timer_rst    <= (w_next == ST_IDLE) || (w_next == ST_PRESTART);
      r_timer_enable <= (w_next == ST_PLAYING);
      r_game_active  <= (w_next == ST_PLAYING);
      r_game_over    <= (w_next == ST_GAME_OVER);
      r_score_clr    <= w_enter_pre;

      if (w_enter_pre) begin
        r_pre_secs <= PRE_LOAD;
        r_ms_cnt   <= '0;
      end else if (r_state == ST_PRESTART) begin
        if (w_next != ST_PRESTART) begin
          r_pre_secs <= '0;
          r_ms_cnt   <= '0;
        end else if (w_sec_done) begin
          r_ms_cnt <= '0;
          if (r_pre_secs != '0) r_pre_secs <= r_pre_secs - PW'(1);
        end else if (w_tick) begin
          r_ms_cnt <= r_ms_cnt + MW'(1);
        end
      end

      if (w_enter_go) begin
        r_hold <= '0;
      end else if ((r_state == ST_GAME_OVER) && w_tick && !w_hold_sat) begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign timer_rst     = r_timer_rst;
  assign timer_enable  = r_timer_enable;
  assign game_active   = r_game_active;
  assign score_clr     = r_score_clr;
  assign game_over     = r_game_over;
  assign prestart_secs = r_pre_secs;
  assign state         = r_state;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller with a countdown-timer model attached.
// Expected timings come from the round rules expressed as plain arithmetic.
module tb_game_controller;

  localparam int CLKS     = 4;
  localparam int GAME_LEN = 2;
  localparam int PRE_S    = 2;
  localparam int HOLD_MS  = 5;
  localparam int TW = $clog2(1000 * GAME_LEN);
  localparam int PW = $clog2(PRE_S + 1);

  // Round arithmetic: a second of get-ready lasts 1000 ms of CLKS cycles; the timer must
  // run TIMER_LOAD ms to reach zero and the controller needs one more cycle to see it.
  localparam int SEC_CYC    = 1000 * CLKS;
  localparam int PRE_CYC    = PRE_S * SEC_CYC;
  localparam int TIMER_LOAD = 1000 * GAME_LEN - 1;
  localparam int PLAY_CYC   = TIMER_LOAD * CLKS + 1;
  localparam int HOLD_CYC   = HOLD_MS * CLKS;

  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_PLAY = 3'd2, S_PAUSE = 3'd3, S_GO = 3'd4;

  logic          clk, rst_n, start_btn, pause_btn;
  logic [TW-1:0] timer_ms;
  logic          timer_rst, timer_enable, game_active, score_clr, game_over;
  logic [PW-1:0] prestart_secs;
  logic [2:0]    state;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_prev;
  logic [2:0] mon_exp;
  int         tdiv;

  game_controller #(
    .GAME_LENGTH_SECONDS(GAME_LEN),
    .CLKS_PER_MS        (CLKS),
    .PRESTART_SECONDS   (PRE_S),
    .GAMEOVER_HOLD_MS   (HOLD_MS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .timer_ms     (timer_ms),
    .timer_rst    (timer_rst),
    .timer_enable (timer_enable),
    .game_active  (game_active),
    .score_clr    (score_clr),
    .game_over    (game_over),
    .prestart_secs(prestart_secs),
    .state        (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // countdown timer model: reload on timer_rst, count ms while enabled, stick at zero
  always @(posedge clk) begin
    if (timer_rst) begin
      timer_ms <= TW'(TIMER_LOAD);
      tdiv     <= 0;
    end else if (timer_enable) begin
      if (tdiv == CLKS - 1) begin
        tdiv <= 0;
        if (timer_ms != '0) timer_ms <= timer_ms - 1'b1;
      end else begin
        tdiv <= tdiv + 1;
      end
    end
  end

  // scoreboard: every state change must match the next queued expectation
  always @(posedge clk) begin
    #1;
    if (state !== mon_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL state_seq: unexpected change %0d -> %0d, required no change", mon_prev, state);
      end else begin
        mon_exp = exp_q.pop_front();
        if (state !== mon_exp) begin
          n_fail++;
          $display("FAIL state_seq: got state %0d, required %0d", state, mon_exp);
        end
      end
      mon_prev = state;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic bit exp_accept(input int c);
    return c >= HOLD_CYC;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
  endtask

  task automatic run_to_state(input logic [2:0] target, input int budget, output int n);
    n = 0;
    while (state !== target && n < budget) begin
      tick();
      n++;
    end
    if (state !== target) n = -1;
  endtask

  task automatic test_reset();
    int toggles;
    rst_n = 1'b0; start_btn = 1'b1; pause_btn = 1'b1;
    repeat (5) tick();
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required %0d", state, S_IDLE); end
    n_checks++; if (timer_rst !== 1'b1) begin n_fail++; $display("FAIL rst_timer_rst: got %b required 1", timer_rst); end
    n_checks++; if ({timer_enable, game_active, score_clr, game_over} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_flags: got %b required 0000", {timer_enable, game_active, score_clr, game_over}); end
    n_checks++; if (prestart_secs !== '0) begin n_fail++; $display("FAIL rst_prestart: got %0d required 0", prestart_secs); end
    rst_n = 1'b1;
    toggles = 0;
    repeat (50) begin
      tick();
      if (state !== S_IDLE || timer_rst !== 1'b1 || timer_enable !== 1'b0 || game_active !== 1'b0 ||
          score_clr !== 1'b0 || game_over !== 1'b0 || prestart_secs !== '0) toggles++;
    end
    n_checks++; if (toggles != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d disturbed cycles required 0", toggles); end
    start_btn = 1'b0; pause_btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_prestart();
    int n, pk;
    exp_q.push_back(S_PRE); exp_q.push_back(S_PLAY);
    press_start();
    n_checks++; if (state !== S_PRE) begin n_fail++; $display("FAIL pre_entry: got %0d required %0d", state, S_PRE); end
    n_checks++; if (score_clr !== 1'b1) begin n_fail++; $display("FAIL score_clr_pulse: got %b required 1", score_clr); end
    n_checks++; if (prestart_secs !== PW'(PRE_S)) begin n_fail++; $display("FAIL pre_load: got %0d required %0d", prestart_secs, PRE_S); end
    n_checks++; if (timer_rst !== 1'b1 || timer_enable !== 1'b0) begin
      n_fail++; $display("FAIL pre_timer: got rst=%b en=%b required rst=1 en=0", timer_rst, timer_enable); end
    tick();
    n_checks++; if (score_clr !== 1'b0) begin n_fail++; $display("FAIL score_clr_width: got %b required 0", score_clr); end
    pk = $urandom_range(10, 3000);
    for (int k = 2; k < SEC_CYC; k++) begin
      pause_btn = (k == pk);
      tick();
    end
    pause_btn = 1'b0;
    n_checks++; if (prestart_secs !== PW'(PRE_S) || state !== S_PRE) begin
      n_fail++; $display("FAIL pre_hold: got secs=%0d state=%0d required secs=%0d state=%0d", prestart_secs, state, PRE_S, S_PRE); end
    tick();
    n_checks++; if (prestart_secs !== PW'(PRE_S - 1)) begin
      n_fail++; $display("FAIL pre_decrement: got %0d required %0d", prestart_secs, PRE_S - 1); end
    run_to_state(S_PLAY, PRE_CYC, n);
    n_checks++; if (n != PRE_CYC - SEC_CYC) begin n_fail++; $display("FAIL pre_length: got %0d required %0d", n, PRE_CYC - SEC_CYC); end
    n_checks++; if ({timer_enable, timer_rst, game_active} !== 3'b101) begin
      n_fail++; $display("FAIL play_outputs: got en,rst,act=%b required 101", {timer_enable, timer_rst, game_active}); end
    n_checks++; if (prestart_secs !== '0) begin n_fail++; $display("FAIL play_prestart: got %0d required 0", prestart_secs); end
  endtask

  task automatic test_full_round();
    int play, sk, n;
    exp_q.push_back(S_GO);
    play = 1; n = 0;
    sk = $urandom_range(100, 7000);
    while (state === S_PLAY && n < PLAY_CYC + 50) begin
      start_btn = (n == sk);
      tick();
      n++;
      if (state === S_PLAY) play++;
    end
    start_btn = 1'b0;
    n_checks++; if (play != PLAY_CYC) begin n_fail++; $display("FAIL play_length: got %0d required %0d", play, PLAY_CYC); end
    n_checks++; if (state !== S_GO || game_over !== 1'b1) begin
      n_fail++; $display("FAIL go_entry: got state=%0d go=%b required state=%0d go=1", state, game_over, S_GO); end
    n_checks++; if ({timer_enable, timer_rst, game_active} !== 3'b000) begin
      n_fail++; $display("FAIL go_outputs: got en,rst,act=%b required 000", {timer_enable, timer_rst, game_active}); end
    repeat (HOLD_CYC + 10) tick();
    n_checks++; if (timer_ms !== '0 || game_over !== 1'b1) begin
      n_fail++; $display("FAIL go_hold: got timer=%0d go=%b required timer=0 go=1", timer_ms, game_over); end
  endtask

  task automatic test_pause();
    int n, play, p;
    logic [TW-1:0] frozen;
    exp_q.push_back(S_PRE); exp_q.push_back(S_PLAY); exp_q.push_back(S_PAUSE);
    exp_q.push_back(S_PLAY); exp_q.push_back(S_GO);
    press_start();
    run_to_state(S_PLAY, PRE_CYC + 50, n);
    n_checks++; if (n != PRE_CYC) begin n_fail++; $display("FAIL restart_pre_length: got %0d required %0d", n, PRE_CYC); end
    play = 1;
    p = $urandom_range(200, 7000);
    repeat (p) begin
      tick();
      if (state === S_PLAY) play++;
    end
    press_pause();
    n_checks++; if (state !== S_PAUSE || {timer_enable, timer_rst, game_active} !== 3'b000) begin
      n_fail++; $display("FAIL pause_entry: got state=%0d en,rst,act=%b required state=%0d 000", state, {timer_enable, timer_rst, game_active}, S_PAUSE); end
    frozen = timer_ms;
    repeat (100) tick();
    n_checks++; if (timer_ms !== frozen) begin n_fail++; $display("FAIL timer_frozen: got %0d required %0d", timer_ms, frozen); end
    if ($urandom_range(0, 1) == 1) press_pause();
    else press_start();
    n_checks++; if (state !== S_PLAY) begin n_fail++; $display("FAIL resume: got %0d required %0d", state, S_PLAY); end
    if (state === S_PLAY) play++;
    n = 0;
    while (state === S_PLAY && n < PLAY_CYC + 50) begin
      tick();
      n++;
      if (state === S_PLAY) play++;
    end
    n_checks++; if (play != PLAY_CYC) begin n_fail++; $display("FAIL paused_play_length: got %0d required %0d", play, PLAY_CYC); end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL paused_round_end: got %b required 1", game_over); end
  endtask

  task automatic test_gameover_hold();
    int c, cn;
    bit acc;
    c = 0; cn = 10; acc = 1'b0;
    while (!acc && cn < 64) begin
      while (c < cn) begin tick(); c++; end
      acc = exp_accept(cn);
      if (acc) exp_q.push_back(S_PRE);
      press_start();
      c++;
      n_checks++; if (state !== (acc ? S_PRE : S_GO)) begin
        n_fail++; $display("FAIL go_start_at_%0d: got %0d required %0d", cn, state, acc ? S_PRE : S_GO); end
      cn = c + $urandom_range(1, 5);
    end
    n_checks++; if (score_clr !== 1'b1 || prestart_secs !== PW'(PRE_S) || timer_rst !== 1'b1) begin
      n_fail++; $display("FAIL go_restart_entry: got clr=%b secs=%0d rst=%b required 1 %0d 1", score_clr, prestart_secs, timer_rst, PRE_S); end
    tick();
    n_checks++; if (timer_ms !== TW'(TIMER_LOAD)) begin n_fail++; $display("FAIL timer_reload: got %0d required %0d", timer_ms, TIMER_LOAD); end
  endtask

  task automatic test_reset_prestart();
    repeat ($urandom_range(5, 500)) tick();
    exp_q.push_back(S_IDLE);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (state !== S_IDLE || timer_rst !== 1'b1 || prestart_secs !== '0 || score_clr !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_pre: got state=%0d rst=%b secs=%0d clr=%b required 0 1 0 0", state, timer_rst, prestart_secs, score_clr); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL post_rst_idle: got %0d required %0d", state, S_IDLE); end
  endtask

  task automatic test_reset_paused();
    int n;
    exp_q.push_back(S_PRE); exp_q.push_back(S_PLAY);
    press_start();
    run_to_state(S_PLAY, PRE_CYC + 50, n);
    n_checks++; if (n != PRE_CYC) begin n_fail++; $display("FAIL rp_pre_length: got %0d required %0d", n, PRE_CYC); end
    repeat ($urandom_range(100, 3000)) tick();
    exp_q.push_back(S_PAUSE);
    press_pause();
    n_checks++; if (state !== S_PAUSE) begin n_fail++; $display("FAIL rp_pause: got %0d required %0d", state, S_PAUSE); end
    repeat ($urandom_range(5, 50)) tick();
    exp_q.push_back(S_IDLE);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (state !== S_IDLE || {timer_rst, timer_enable, game_active} !== 3'b100) begin
      n_fail++; $display("FAIL async_rst_pause: got state=%0d rst,en,act=%b required 0 100", state, {timer_rst, timer_enable, game_active}); end
    tick(); tick();
    n_checks++; if (timer_ms !== TW'(TIMER_LOAD)) begin n_fail++; $display("FAIL rst_timer_reload: got %0d required %0d", timer_ms, TIMER_LOAD); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_same_cycle();
    int n;
    exp_q.push_back(S_PRE); exp_q.push_back(S_PLAY); exp_q.push_back(S_GO);
    press_start();
    run_to_state(S_PLAY, PRE_CYC + 50, n);
    n_checks++; if (n != PRE_CYC) begin n_fail++; $display("FAIL sc_pre_length: got %0d required %0d", n, PRE_CYC); end
    n = 0;
    while (timer_ms !== '0 && n < PLAY_CYC + 50) begin
      tick();
      n++;
    end
    n_checks++; if (n != PLAY_CYC - 1 || state !== S_PLAY) begin
      n_fail++; $display("FAIL zero_in_play: got n=%0d state=%0d required n=%0d state=%0d", n, state, PLAY_CYC - 1, S_PLAY); end
    press_pause();
    n_checks++; if (state !== S_GO || game_over !== 1'b1) begin
      n_fail++; $display("FAIL zero_beats_pause: got state=%0d go=%b required %0d 1", state, game_over, S_GO); end
    repeat (5) tick();
    n_checks++; if (state !== S_GO) begin n_fail++; $display("FAIL go_stays: got %0d required %0d", state, S_GO); end
  endtask

  initial begin
    mon_prev  = S_IDLE;
    rst_n     = 1'b0;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    test_reset();
    test_prestart();
    test_full_round();
    test_pause();
    test_gameover_hold();
    test_reset_prestart();
    test_reset_paused();
    test_same_cycle();
    tick(); tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL exp_q_drained: got %0d pending required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
